// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared CNN definitions: default activation width, unsigned max helper and
// index-width helper used by the pooling stage and its line buffer.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 20;
  localparam int UMAX_W         = 64;

  // Width of an index that must address n entries; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [UMAX_W-1:0] umax(input logic [UMAX_W-1:0] a,
                                             input logic [UMAX_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_if.sv
// Pixel-in / window-out stream bundle for the 2x2 max-pool stage.
interface maxpool_2x2_stream_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ROW_W      = 4,
  parameter int COL_W      = 4
);
  // Handshake: in_valid qualifies in_data on every rising edge; there is no
  // ready, so the sink must take every single-cycle out_valid pulse.
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;
  logic                  frame_done;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_row, out_col, frame_done
  );
endinterface

// File: rtl/pool_line_buffer.sv
// Half-width row store for partial 2x2 maxima: one write port, one
// asynchronous read port, storage left unreset.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [idx_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [idx_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pool over a raster-order single-channel feature
// map; even rows fold pairs into the line buffer, odd rows finish the windows.
module maxpool_2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  maxpool_2x2_stream_if.slave  bus
);

  localparam int COLS_W   = idx_w(IMG_WIDTH);
  localparam int ROWS_W   = idx_w(IMG_HEIGHT);
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_AW    = idx_w(LB_DEPTH);
  localparam int ROW_W    = idx_w(IMG_HEIGHT / 2);
  localparam int COL_W    = idx_w(IMG_WIDTH / 2);

  if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
    $error("maxpool_2x2_stream: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
    $error("maxpool_2x2_stream: IMG_HEIGHT must be even and >= 2");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > UMAX_W) begin : g_bad_data_width
    $error("maxpool_2x2_stream: DATA_WIDTH out of range");
  end

  function automatic logic [DATA_WIDTH-1:0] max_dw(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [UMAX_W-1:0] m;
    m = umax(UMAX_W'(a), UMAX_W'(b));
    return m[DATA_WIDTH-1:0];
  endfunction

  logic [COLS_W-1:0]     col_cnt;
  logic [ROWS_W-1:0]     row_cnt;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] col_max;
  logic [DATA_WIDTH-1:0] lb_rdata;
  logic [LB_AW-1:0]      lb_addr;
  logic                  lb_we;
  logic                  last_col;
  logic                  last_row;

  assign last_col = (col_cnt == COLS_W'(IMG_WIDTH - 1));
  assign last_row = (row_cnt == ROWS_W'(IMG_HEIGHT - 1));
  assign lb_addr  = LB_AW'(col_cnt >> 1);
  // Writes only on even rows and reads only on odd rows, so one shared address suffices.
  assign lb_we    = bus.in_valid & ~row_cnt[0] & col_cnt[0];
  assign pair_max = max_dw(hold_reg, bus.in_data);
  assign col_max  = max_dw(lb_rdata, bus.in_data);

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt        <= '0;
      row_cnt        <= '0;
      hold_reg       <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_row    <= '0;
      bus.out_col    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.in_valid) begin
        case ({row_cnt[0], col_cnt[0]})
          2'b00:   hold_reg <= bus.in_data;
          2'b10:   hold_reg <= col_max;
          2'b11: begin
            bus.out_data   <= pair_max;
            bus.out_row    <= ROW_W'(row_cnt >> 1);
            bus.out_col    <= COL_W'(col_cnt >> 1);
            bus.out_valid  <= 1'b1;
            bus.frame_done <= last_row & last_col;
          end
          default: ;
        endcase

        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule
